// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   Architectural general-purpose register file for the pipelined MIPS core.
//   Commits write-back results, serves the two decode-stage source operands
//   combinationally (with optional write-first bypass), provides a registered
//   debug read port, and counts committed writes for bring-up.
//
// Ports
//   clk                        core clock, all state updates on rising edge
//   rst_n                      synchronous active-low reset
//   in_reg_write               write enable from write-back stage
//   in_write_back_destination  write index
//   in_write_data              write data
//   in_read_reg_1              rs index from decode
//   in_read_reg_2              rt index from decode
//   in_debug_reg               debug read index
//   read_data_1_out            rs operand (combinational)
//   read_data_2_out            rt operand (combinational)
//   debug_data_out             debug read data (1-cycle latency, no bypass)
//   write_count_out            committed writes since reset (wraps)
// ---------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS_EN  = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_reg_write,
    input  logic [ADDR_WIDTH-1:0] in_write_back_destination,
    input  logic [DATA_WIDTH-1:0] in_write_data,
    input  logic [ADDR_WIDTH-1:0] in_read_reg_1,
    input  logic [ADDR_WIDTH-1:0] in_read_reg_2,
    input  logic [ADDR_WIDTH-1:0] in_debug_reg,
    output logic [DATA_WIDTH-1:0] read_data_1_out,
    output logic [DATA_WIDTH-1:0] read_data_2_out,
    output logic [DATA_WIDTH-1:0] debug_data_out,
    output logic [CNT_WIDTH-1:0]  write_count_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] debug_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  commit;

    // Entry 0 is the hardwired zero register, so a write aimed at it is not
    // a commit and is neither stored nor counted.
    assign commit  = in_reg_write && (in_write_back_destination != '0);
    assign count_d = count_q + CNT_WIDTH'(1);

    // Write-first read: forward the in-flight write when it targets the
    // same nonzero index, otherwise return the stored value.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] dest,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] r;
        r = stored;
        if (idx == '0) begin
            r = '0;
        end else if (BYPASS_EN && we && (dest == idx)) begin
            r = wdata;
        end
        return r;
    endfunction

    always_comb begin
        read_data_1_out = read_port(in_read_reg_1, in_reg_write,
                                    in_write_back_destination, in_write_data,
                                    regs_q[in_read_reg_1]);
        read_data_2_out = read_port(in_read_reg_2, in_reg_write,
                                    in_write_back_destination, in_write_data,
                                    regs_q[in_read_reg_2]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            debug_q <= '0;
            count_q <= '0;
        end else begin
            // Debug samples storage before this edge's write lands, so a
            // same-index write shows up one cycle later.
            debug_q <= regs_q[in_debug_reg];
            if (commit) begin
                regs_q[in_write_back_destination] <= in_write_data;
                count_q                           <= count_d;
            end
        end
    end

    assign debug_data_out  = debug_q;
    assign write_count_out = count_q;

endmodule
